// File: rtl/ipif_rsp_pkg.sv
// Shared types and beat-geometry helpers for the IPIF master burst responder.
package ipif_rsp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK     = 3'd1,
        RD_DATA = 3'd2,
        WR_DATA = 3'd3,
        CMPLT   = 3'd4
    } state_t;

    localparam int LEN_W = 20;
    // One bit wider than the length so ceil(length / bytes) never overflows.
    localparam int CNT_W = LEN_W + 1;

    function automatic int bytes_per_beat(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int beat_shift(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/ipif_rsp_mem.sv
// Backing store: single-port 2**MEM_AW x DATA_W, synchronous write, combinational read.
module ipif_rsp_mem #(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [MEM_AW-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**MEM_AW];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ipif_mst_burst_responder.sv
// IPIF master-side burst responder backed by a local memory.
// Optional build macro IPIF_RSP_ERR_CHECK_EN enables zero-length / out-of-range command errors.
module ipif_mst_burst_responder
    import ipif_rsp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int MEM_AW = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ip2bus_mstrd_req,
    input  logic              ip2bus_mstwr_req,
    input  logic [31:0]       ip2bus_mst_addr,
    input  logic [19:0]       ip2bus_mst_length,
    input  logic              ip2bus_mst_type,
    output logic              bus2ip_mst_cmdack,
    output logic              bus2ip_mst_cmplt,
    output logic              bus2ip_mst_error,
    output logic [DATA_W-1:0] bus2ip_mstrd_d,
    output logic              bus2ip_mstrd_sof_n,
    output logic              bus2ip_mstrd_eof_n,
    output logic              bus2ip_mstrd_src_rdy_n,
    input  logic              ip2bus_mstrd_dst_rdy_n,
    input  logic [DATA_W-1:0] ip2bus_mstwr_d,
    input  logic              ip2bus_mstwr_sof_n,
    input  logic              ip2bus_mstwr_eof_n,
    input  logic              ip2bus_mstwr_src_rdy_n,
    output logic              bus2ip_mstwr_dst_rdy_n,
    output logic [2:0]        fsm_state
);

    localparam int BPB   = bytes_per_beat(DATA_W);
    localparam int SHIFT = beat_shift(DATA_W);

    state_t            state;
    logic [MEM_AW-1:0] word_idx;
    logic [CNT_W-1:0]  beat_cnt;
    logic [CNT_W-1:0]  beats;
    logic              is_rd;
    logic              is_err;

    logic [CNT_W-1:0]  req_beats_raw;
    logic [CNT_W-1:0]  req_beats;
    logic [MEM_AW-1:0] req_idx;
    logic              req_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic              last_beat;
    logic              rd_xfer;
    logic              unused_inputs;

    assign req_beats_raw = ({1'b0, ip2bus_mst_length} + CNT_W'(BPB - 1)) >> SHIFT;
    assign req_beats     = (!ip2bus_mst_type || req_beats_raw == '0) ? CNT_W'(1) : req_beats_raw;
    assign req_idx       = ip2bus_mst_addr[SHIFT +: MEM_AW];

`ifdef IPIF_RSP_ERR_CHECK_EN
    logic [32:0] req_end;
    assign req_end = 33'(req_idx) + 33'(req_beats);
    assign req_err = (ip2bus_mst_length == '0) || (req_end > (33'd1 << MEM_AW));
`else
    assign req_err = 1'b0;
`endif

    // Beat handshake (both directions): a beat moves on a rising edge where the
    // source's src_rdy_n and the sink's dst_rdy_n are both low; the source holds
    // data and framing unchanged until that edge.
    assign rd_xfer   = (state == RD_DATA) && !bus2ip_mstrd_src_rdy_n && !ip2bus_mstrd_dst_rdy_n;
    assign mem_we    = (state == WR_DATA) && !ip2bus_mstwr_src_rdy_n;
    assign last_beat = (beat_cnt == beats - 1'b1);

    // During reads the port looks one word ahead so the next beat is ready at transfer.
    assign mem_addr  = (state == RD_DATA) ? word_idx + 1'b1 : word_idx;
    assign fsm_state = state;

    assign unused_inputs = ^{ip2bus_mst_addr, ip2bus_mstwr_sof_n, ip2bus_mstwr_eof_n};

    ipif_rsp_mem #(
        .DATA_W(DATA_W),
        .MEM_AW(MEM_AW)
    ) u_mem (
        .clock(clock),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(ip2bus_mstwr_d),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state                  <= IDLE;
            word_idx               <= '0;
            beat_cnt               <= '0;
            beats                  <= '0;
            is_rd                  <= 1'b0;
            is_err                 <= 1'b0;
            bus2ip_mst_cmdack      <= 1'b0;
            bus2ip_mst_cmplt       <= 1'b0;
            bus2ip_mst_error       <= 1'b0;
            bus2ip_mstrd_d         <= '0;
            bus2ip_mstrd_sof_n     <= 1'b1;
            bus2ip_mstrd_eof_n     <= 1'b1;
            bus2ip_mstrd_src_rdy_n <= 1'b1;
            bus2ip_mstwr_dst_rdy_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (ip2bus_mstrd_req || ip2bus_mstwr_req) begin
                        state             <= ACK;
                        bus2ip_mst_cmdack <= 1'b1;
                        word_idx          <= req_idx;
                        beats             <= req_beats;
                        beat_cnt          <= '0;
                        is_rd             <= ip2bus_mstrd_req;
                        is_err            <= req_err;
                    end
                end
                ACK: begin
                    bus2ip_mst_cmdack <= 1'b0;
                    if (is_err) begin
                        state            <= CMPLT;
                        bus2ip_mst_cmplt <= 1'b1;
                        bus2ip_mst_error <= 1'b1;
                    end else if (is_rd) begin
                        state                  <= RD_DATA;
                        bus2ip_mstrd_d         <= mem_rdata;
                        bus2ip_mstrd_src_rdy_n <= 1'b0;
                        bus2ip_mstrd_sof_n     <= 1'b0;
                        bus2ip_mstrd_eof_n     <= (beats != CNT_W'(1));
                    end else begin
                        state                  <= WR_DATA;
                        bus2ip_mstwr_dst_rdy_n <= 1'b0;
                    end
                end
                RD_DATA: begin
                    if (rd_xfer) begin
                        if (last_beat) begin
                            state                  <= CMPLT;
                            bus2ip_mst_cmplt       <= 1'b1;
                            bus2ip_mstrd_src_rdy_n <= 1'b1;
                            bus2ip_mstrd_sof_n     <= 1'b1;
                            bus2ip_mstrd_eof_n     <= 1'b1;
                        end else begin
                            word_idx           <= word_idx + 1'b1;
                            beat_cnt           <= beat_cnt + 1'b1;
                            bus2ip_mstrd_d     <= mem_rdata;
                            bus2ip_mstrd_sof_n <= 1'b1;
                            bus2ip_mstrd_eof_n <= (beat_cnt + CNT_W'(2) != beats);
                        end
                    end
                end
                WR_DATA: begin
                    if (mem_we) begin
                        if (last_beat) begin
                            state                  <= CMPLT;
                            bus2ip_mst_cmplt       <= 1'b1;
                            bus2ip_mstwr_dst_rdy_n <= 1'b1;
                        end else begin
                            word_idx <= word_idx + 1'b1;
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                CMPLT: begin
                    state            <= IDLE;
                    bus2ip_mst_cmplt <= 1'b0;
                    bus2ip_mst_error <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ipif_mst_burst_responder.sv
// Directed self-checking bench for ipif_mst_burst_responder (DATA_W=32, MEM_AW=8).
module tb_ipif_mst_burst_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ip2bus_mstrd_req = 1'b0;
    logic        ip2bus_mstwr_req = 1'b0;
    logic [31:0] ip2bus_mst_addr = '0;
    logic [19:0] ip2bus_mst_length = '0;
    logic        ip2bus_mst_type = 1'b0;
    logic        bus2ip_mst_cmdack;
    logic        bus2ip_mst_cmplt;
    logic        bus2ip_mst_error;
    logic [31:0] bus2ip_mstrd_d;
    logic        bus2ip_mstrd_sof_n;
    logic        bus2ip_mstrd_eof_n;
    logic        bus2ip_mstrd_src_rdy_n;
    logic        ip2bus_mstrd_dst_rdy_n = 1'b1;
    logic [31:0] ip2bus_mstwr_d = '0;
    logic        ip2bus_mstwr_sof_n = 1'b1;
    logic        ip2bus_mstwr_eof_n = 1'b1;
    logic        ip2bus_mstwr_src_rdy_n = 1'b1;
    logic        bus2ip_mstwr_dst_rdy_n;
    logic [2:0]  fsm_state;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    ipif_mst_burst_responder #(.DATA_W(32), .MEM_AW(8)) dut (
        .clock                 (clock),
        .reset                 (reset),
        .ip2bus_mstrd_req      (ip2bus_mstrd_req),
        .ip2bus_mstwr_req      (ip2bus_mstwr_req),
        .ip2bus_mst_addr       (ip2bus_mst_addr),
        .ip2bus_mst_length     (ip2bus_mst_length),
        .ip2bus_mst_type       (ip2bus_mst_type),
        .bus2ip_mst_cmdack     (bus2ip_mst_cmdack),
        .bus2ip_mst_cmplt      (bus2ip_mst_cmplt),
        .bus2ip_mst_error      (bus2ip_mst_error),
        .bus2ip_mstrd_d        (bus2ip_mstrd_d),
        .bus2ip_mstrd_sof_n    (bus2ip_mstrd_sof_n),
        .bus2ip_mstrd_eof_n    (bus2ip_mstrd_eof_n),
        .bus2ip_mstrd_src_rdy_n(bus2ip_mstrd_src_rdy_n),
        .ip2bus_mstrd_dst_rdy_n(ip2bus_mstrd_dst_rdy_n),
        .ip2bus_mstwr_d        (ip2bus_mstwr_d),
        .ip2bus_mstwr_sof_n    (ip2bus_mstwr_sof_n),
        .ip2bus_mstwr_eof_n    (ip2bus_mstwr_eof_n),
        .ip2bus_mstwr_src_rdy_n(ip2bus_mstwr_src_rdy_n),
        .bus2ip_mstwr_dst_rdy_n(bus2ip_mstwr_dst_rdy_n),
        .fsm_state             (fsm_state)
    );

    // Clock; inputs change and outputs are sampled on the falling edge.
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmdack"}, 32'(bus2ip_mst_cmdack), 32'd0);
        check({tag, "_cmplt"}, 32'(bus2ip_mst_cmplt), 32'd0);
        check({tag, "_error"}, 32'(bus2ip_mst_error), 32'd0);
        check({tag, "_rd_d"}, bus2ip_mstrd_d, 32'd0);
        check({tag, "_framing"}, {29'd0, bus2ip_mstrd_sof_n, bus2ip_mstrd_eof_n,
                                  bus2ip_mstrd_src_rdy_n}, 32'd7);
        check({tag, "_wr_rdy"}, 32'(bus2ip_mstwr_dst_rdy_n), 32'd1);
    endtask

    // Write command: n beats of d0, d0+1, ... with one idle source cycle after beat 1.
    task automatic wr_cmd(input logic [31:0] a, input logic [19:0] len, input logic typ,
                          input int n, input logic [31:0] d0);
        int  sent = 0;
        int  cyc  = 0;
        bit  gap  = 0;
        @(negedge clock);
        check("wr_pre_cmplt", 32'(bus2ip_mst_cmplt), 32'd0);
        ip2bus_mstwr_req  = 1'b1;
        ip2bus_mst_addr   = a;
        ip2bus_mst_length = len;
        ip2bus_mst_type   = typ;
        @(negedge clock);
        check("wr_cmdack", 32'(bus2ip_mst_cmdack), 32'd1);
        ip2bus_mstwr_req = 1'b0;
        while (sent < n && cyc < 40) begin
            @(negedge clock);
            cyc++;
            if (cyc == 1) check("wr_cmdack_one", 32'(bus2ip_mst_cmdack), 32'd0);
            if (sent == 2 && !gap) begin
                gap = 1;
                ip2bus_mstwr_src_rdy_n = 1'b1;
                ip2bus_mstwr_d         = 32'hDEAD_BEEF;
            end else begin
                ip2bus_mstwr_src_rdy_n = 1'b0;
                ip2bus_mstwr_d         = d0 + 32'(sent);
                ip2bus_mstwr_sof_n     = (sent != 0);
                ip2bus_mstwr_eof_n     = (sent != n - 1);
                if (!bus2ip_mstwr_dst_rdy_n) sent++;
            end
        end
        check("wr_beats", 32'(sent), 32'(n));
        @(negedge clock);
        ip2bus_mstwr_src_rdy_n = 1'b1;
        ip2bus_mstwr_sof_n     = 1'b1;
        ip2bus_mstwr_eof_n     = 1'b1;
        check("wr_cmplt", 32'(bus2ip_mst_cmplt), 32'd1);
        check("wr_error", 32'(bus2ip_mst_error), 32'd0);
        check("wr_rdy_off", 32'(bus2ip_mstwr_dst_rdy_n), 32'd1);
    endtask

    // Read command: beats compared against exp_q; toggle stalls every other cycle.
    task automatic rd_cmd(input logic [31:0] a, input logic [19:0] len, input logic typ,
                          input bit toggle, input bit with_wr);
        int          got = 0;
        int          cyc = 0;
        bit          prev_stall = 0;
        logic [31:0] prev_d = '0;
        logic [31:0] exp;
        @(negedge clock);
        check("rd_pre_cmplt", 32'(bus2ip_mst_cmplt), 32'd0);
        ip2bus_mstrd_req  = 1'b1;
        ip2bus_mstwr_req  = with_wr;
        ip2bus_mst_addr   = a;
        ip2bus_mst_length = len;
        ip2bus_mst_type   = typ;
        ip2bus_mstrd_dst_rdy_n = 1'b1;
        @(negedge clock);
        check("rd_cmdack", 32'(bus2ip_mst_cmdack), 32'd1);
        ip2bus_mstrd_req = 1'b0;
        while (exp_q.size() > 0 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            ip2bus_mstrd_dst_rdy_n = toggle ? ~ip2bus_mstrd_dst_rdy_n : 1'b0;
            if (!bus2ip_mstrd_src_rdy_n) begin
                if (prev_stall) check("rd_stable", bus2ip_mstrd_d, prev_d);
                prev_stall = ip2bus_mstrd_dst_rdy_n;
                prev_d     = bus2ip_mstrd_d;
                if (!ip2bus_mstrd_dst_rdy_n) begin
                    exp = exp_q.pop_front();
                    check("rd_data", bus2ip_mstrd_d, exp);
                    check("rd_sof_n", 32'(bus2ip_mstrd_sof_n), (got == 0) ? 32'd0 : 32'd1);
                    check("rd_eof_n", 32'(bus2ip_mstrd_eof_n), (exp_q.size() == 0) ? 32'd0 : 32'd1);
                    got++;
                end
            end
        end
        check("rd_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        @(negedge clock);
        ip2bus_mstrd_dst_rdy_n = 1'b1;
        check("rd_cmplt", 32'(bus2ip_mst_cmplt), 32'd1);
        check("rd_error", 32'(bus2ip_mst_error), 32'd0);
        check("rd_src_off", 32'(bus2ip_mstrd_src_rdy_n), 32'd1);
        check("rd_wr_idle", 32'(bus2ip_mstwr_dst_rdy_n), 32'd1);
    endtask

`ifdef IPIF_RSP_ERR_CHECK_EN
    task automatic err_cmd(input string tag, input logic [31:0] a, input logic [19:0] len);
        @(negedge clock);
        ip2bus_mstrd_req  = 1'b1;
        ip2bus_mst_addr   = a;
        ip2bus_mst_length = len;
        ip2bus_mst_type   = 1'b1;
        @(negedge clock);
        check({tag, "_cmdack"}, 32'(bus2ip_mst_cmdack), 32'd1);
        ip2bus_mstrd_req = 1'b0;
        @(negedge clock);
        check({tag, "_cmplt"}, 32'(bus2ip_mst_cmplt), 32'd1);
        check({tag, "_error"}, 32'(bus2ip_mst_error), 32'd1);
        check({tag, "_no_src"}, 32'(bus2ip_mstrd_src_rdy_n), 32'd1);
        @(negedge clock);
        check({tag, "_error_clr"}, 32'(bus2ip_mst_error), 32'd0);
    endtask
`endif

    initial begin
        // Reset values
        @(negedge clock);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clock);
        check("rst_idle_cmdack", 32'(bus2ip_mst_cmdack), 32'd0);

        // Write 0xA..0xD to words 4..7, read back with stalls every other cycle
        wr_cmd(32'h10, 20'd16, 1'b1, 4, 32'hA);
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        rd_cmd(32'h10, 20'd16, 1'b1, 1'b1, 1'b0);

        // Read and write requested together: read first, write follows without req drop
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        rd_cmd(32'h10, 20'd16, 1'b1, 1'b0, 1'b1);
        wr_cmd(32'h10, 20'd16, 1'b1, 4, 32'h20);
        exp_q = '{32'h20, 32'h21, 32'h22, 32'h23};
        rd_cmd(32'h10, 20'd16, 1'b1, 1'b1, 1'b0);

        // Single-beat type ignores a 64-byte length
        exp_q = '{32'h20};
        rd_cmd(32'h10, 20'd64, 1'b0, 1'b0, 1'b0);

`ifdef IPIF_RSP_ERR_CHECK_EN
        err_cmd("len0", 32'h14, 20'd0);
        err_cmd("ovf", 32'h3F8, 20'd16);
        wr_cmd(32'h3F8, 20'd8, 1'b1, 2, 32'h40);
        exp_q = '{32'h40, 32'h41};
        rd_cmd(32'h3F8, 20'd8, 1'b1, 1'b0, 1'b0);
`else
        // Zero length is one beat; burst from word 254 wraps to words 0,1
        exp_q = '{32'h21};
        rd_cmd(32'h14, 20'd0, 1'b1, 1'b0, 1'b0);
        wr_cmd(32'h3F8, 20'd16, 1'b1, 4, 32'h30);
        exp_q = '{32'h32, 32'h33};
        rd_cmd(32'h0, 20'd6, 1'b1, 1'b0, 1'b0);
        exp_q = '{32'h30, 32'h31, 32'h32, 32'h33};
        rd_cmd(32'h3F9, 20'd13, 1'b1, 1'b1, 1'b0);
`endif

        // Reset during beat 2 of a 4-beat read
        @(negedge clock);
        ip2bus_mstrd_req       = 1'b1;
        ip2bus_mst_addr        = 32'h10;
        ip2bus_mst_length      = 20'd16;
        ip2bus_mst_type        = 1'b1;
        ip2bus_mstrd_dst_rdy_n = 1'b0;
        @(negedge clock);
        check("mid_cmdack", 32'(bus2ip_mst_cmdack), 32'd1);
        ip2bus_mstrd_req = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("mid_beat1", bus2ip_mstrd_d, 32'h21);
        @(negedge clock);
        check("mid_beat2", bus2ip_mstrd_d, 32'h22);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        @(negedge clock);
        reset = 1'b0;
        ip2bus_mstrd_dst_rdy_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("post_rst_no_cmplt", 32'(bus2ip_mst_cmplt), 32'd0);
            check("post_rst_no_src", 32'(bus2ip_mstrd_src_rdy_n), 32'd1);
        end
        exp_q = '{32'h20, 32'h21, 32'h22, 32'h23};
        rd_cmd(32'h10, 20'd16, 1'b1, 1'b0, 1'b0);

        @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
